// File: rtl/hazard_unit.sv
// Stall/flush controller for the five-stage core, with a parameterised data-memory freeze and a stall counter.
// Build option: define HAZARD_FWD_EN when the core has EX/MEM forwarding (RAW stalls then come only from load-use).
module hazard_unit #(
  parameter int REGADDR   = 5,
  parameter int MEMWAIT   = 2,
  parameter int STALLCNTW = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [REGADDR-1:0]   id_rs,
  input  logic [REGADDR-1:0]   id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic [REGADDR-1:0]   ex_rd,
  input  logic                 ex_regwrite,
  input  logic                 ex_memread,
  input  logic [REGADDR-1:0]   mem_rd,
  input  logic                 mem_regwrite,
  input  logic                 mem_access,
  input  logic                 branch_taken,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 pipe_en,
  output logic [STALLCNTW-1:0] stall_count
);

  localparam int WCW = (MEMWAIT > 0) ? $clog2(MEMWAIT + 1) : 1;

  typedef enum logic [1:0] {RUN, MWAIT, MDONE} state_t;

  state_t         state;
  logic [WCW-1:0] wcnt;

  logic ex_hit, mem_hit, load_use, raw, freeze;

  // Register 0 is hardwired, so it never creates a dependency.
  always_comb begin
    ex_hit  = (id_uses_rs && id_rs != '0 && id_rs == ex_rd) ||
              (id_uses_rt && id_rt != '0 && id_rt == ex_rd);
    mem_hit = (id_uses_rs && id_rs != '0 && id_rs == mem_rd) ||
              (id_uses_rt && id_rt != '0 && id_rt == mem_rd);
    load_use = ex_memread && ex_regwrite && ex_hit;
  end

`ifdef HAZARD_FWD_EN
  logic unused_mem;
  assign unused_mem = mem_hit ^ mem_regwrite;
  assign raw = load_use;
`else
  assign raw = load_use || (ex_regwrite && ex_hit) || (mem_regwrite && mem_hit);
`endif

  // The triggering RUN cycle is already frozen; MDONE lets the held MEM instruction complete.
  assign freeze = (MEMWAIT > 0) && !clr &&
                  ((state == RUN && mem_access) || state == MWAIT);

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_en     = 1'b1;
    if (clr) begin
      pc_en = 1'b1;
    end else if (freeze) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      pipe_en = 1'b0;
    end else if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (raw) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= RUN;
      wcnt        <= '0;
      stall_count <= '0;
    end else begin
      if (!pc_en && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      case (state)
        RUN: begin
          if (mem_access && MEMWAIT > 0) begin
            wcnt  <= WCW'(MEMWAIT - 1);
            state <= (MEMWAIT == 1) ? MDONE : MWAIT;
          end
        end
        MWAIT: begin
          wcnt <= wcnt - 1'b1;
          if (wcnt == WCW'(1))
            state <= MDONE;
        end
        MDONE:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit (default parameters, MEMWAIT=2), expectations track HAZARD_FWD_EN.
module tb_hazard_unit;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_uses_rs, id_uses_rt, ex_regwrite, ex_memread;
  logic        mem_regwrite, mem_access, branch_taken;
  logic        pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit dut (
    .clk(clk), .clr(clr),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_access(mem_access),
    .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_en(pipe_en), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; mem_access = 0; branch_taken = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Packed view of the control outputs: {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en}
  function automatic logic [4:0] ctl();
    return {pc_en, ifid_en, ifid_flush, idex_bubble, pipe_en};
  endfunction

  initial begin
    idle_in();
    clr = 1'b1;
    #1;
    cycle();
    chk("rst_cnt", stall_count, 0);
    // clr forces enables even with a load-use hazard present
    ex_rd = 5; ex_regwrite = 1; ex_memread = 1; id_rs = 5; id_uses_rs = 1;
    #1;
    chk("clr_force", ctl(), 5'b11001);
    cycle();
    chk("clr_cnt", stall_count, 0);

    // load-use r5 -> one stall cycle
    clr = 1'b0;
    #1;
    chk("lu_ctl", ctl(), 5'b00011);
    cycle();
    idle_in();
    #1;
    chk("lu_after", ctl(), 5'b11001);
    chk("lu_cnt", stall_count, 1);

    // load r0 never matches
    ex_rd = 0; ex_regwrite = 1; ex_memread = 1; id_rs = 0; id_uses_rs = 1;
    #1;
    chk("r0_ctl", ctl(), 5'b11001);
    cycle();
    chk("r0_cnt", stall_count, 1);

    // match on rt that the instruction does not read
    idle_in();
    ex_rd = 7; ex_regwrite = 1; ex_memread = 1; id_rt = 7; id_uses_rt = 0;
    #1;
    chk("unused_rt", ctl(), 5'b11001);

    // branch beats load-use
    id_uses_rt = 1; branch_taken = 1;
    #1;
    chk("br_lu", ctl(), 5'b11111);
    cycle();
    chk("br_cnt", stall_count, 1);

    // ALU r3 in EX then MEM, ID reads rt=3
    idle_in();
    ex_rd = 3; ex_regwrite = 1; id_rt = 3; id_uses_rt = 1;
    #1;
    chk("alu_ex", ctl(), FWD ? 5'b11001 : 5'b00011);
    cycle();
    ex_rd = 0; ex_regwrite = 0; mem_rd = 3; mem_regwrite = 1;
    #1;
    chk("alu_mem", ctl(), FWD ? 5'b11001 : 5'b00011);
    cycle();
    chk("alu_cnt", stall_count, FWD ? 1 : 3);

    // memory freeze with a branch pending; freeze wins, branch acts in MDONE
    idle_in();
    mem_access = 1; branch_taken = 1;
    #1;
    chk("frz_t0", ctl(), 5'b00000);
    cycle();
    chk("frz_t1", ctl(), 5'b00000);
    cycle();
    chk("frz_mdone", ctl(), 5'b11111);
    cycle();
    // still held high: retriggers from RUN
    chk("frz_retrig", ctl(), 5'b00000);
    cycle();
    chk("frz_mwait2", pipe_en, 0);
    chk("frz_cnt", stall_count, FWD ? 4 : 6);

    // clr aborts the wait
    clr = 1'b1;
    #1;
    chk("clr_mwait", ctl(), 5'b11001);
    cycle();
    clr = 1'b0; mem_access = 0; branch_taken = 0;
    #1;
    chk("clr_run", ctl(), 5'b11001);
    chk("clr_cnt2", stall_count, 0);
    cycle();
    chk("clr_run2", pipe_en, 1);

    // saturation of the stall counter
    ex_rd = 9; ex_regwrite = 1; ex_memread = 1; id_rs = 9; id_uses_rs = 1;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_cnt", stall_count, 16'hFFFF);
    chk("sat_pc", pc_en, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage core. Watches register usage in ID, EX and MEM and drives the stall and flush controls for the PC counter and pipeline registers. `pc_en` drives the PC counter's hazard enable input. The main-control enable stays separate and is not driven here. Also freezes the whole pipeline for a parameterized data-memory wait and counts stall cycles.

## Interface
- `REGADDR`, 5, register-address width
- `MEMWAIT`, 2, cycles the pipeline is frozen per data-memory access; 0 disables freezing
- `STALLCNTW`, 16, width of the stall-cycle counter
- `clk` in 1: single clock, rising edge
- `clr` in 1: reset, synchronous, active-high
- `id_rs`, `id_rt` in REGADDR: source registers of the instruction in ID
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction actually reads rs / rt
- `ex_rd` in REGADDR: destination register in EX
- `ex_regwrite` in 1: EX instruction writes a register
- `ex_memread` in 1: EX instruction is a load
- `mem_rd` in REGADDR: destination register in MEM
- `mem_regwrite` in 1: MEM instruction writes a register
- `mem_access` in 1: MEM instruction is a load or store
- `branch_taken` in 1: EX resolved a taken branch or jump
- `pc_en` out 1: PC count/load enable, active HIGH
- `ifid_en` out 1: IF/ID register enable
- `ifid_flush` out 1: clear IF/ID to a NOP
- `idex_bubble` out 1: load a NOP into ID/EX
- `pipe_en` out 1: enable for ID/EX, EX/MEM and MEM/WB
- `stall_count` out STALLCNTW: cycles with `pc_en`=0 since reset

## Operation
- FSM states: RUN, MWAIT, MDONE. A down-counter `wcnt` uses width clog2(MEMWAIT+1).
- **RUN → MWAIT:** on `mem_access`=1 when MEMWAIT>0. Load `wcnt`=MEMWAIT-1.
  - If MEMWAIT=1, go directly to MDONE.
- **MWAIT:** decrement `wcnt` each cycle. At `wcnt`=1, go to MDONE.
- **MDONE:** always returns to RUN next cycle. `mem_access` is ignored in MDONE, because the frozen instruction is still present in MEM and must not re-trigger.
- **Freeze** applies in the RUN cycle that triggers MWAIT, and in every MWAIT cycle. During freeze: `pc_en`=`ifid_en`=`pipe_en`=0 and `ifid_flush`=`idex_bubble`=0.
- **Register match:** a match exists when the register is nonzero and equals the destination. Register 0 never matches.
- **Load-use:** `ex_memread` and `ex_regwrite`, with `ex_rd` matching a used `id_rs` or `id_rt`.
- **Outputs outside freeze,** in priority order:
  1. `branch_taken` → `ifid_flush`=1, `idex_bubble`=1, `pc_en`=1, `ifid_en`=1. Any RAW stall is suppressed, because the ID instruction is squashed.
  2. RAW stall → `pc_en`=0, `ifid_en`=0, `idex_bubble`=1, `ifid_flush`=0.
  3. Otherwise all enables are 1 and flush/bubble are 0.
- `pipe_en`=1 whenever not frozen.
- **stall_count:** increments on each rising edge where `pc_en`=0. Saturates at all-ones.

## Timing
- Hazard outputs are combinational from inputs and the current state, valid in the same cycle. FSM and `stall_count` are registered.
- `clr`=1 at a rising edge sets: state RUN, `wcnt` 0, `stall_count` 0.
- While `clr`=1, outputs are forced to `pc_en`=`ifid_en`=`pipe_en`=1 and `ifid_flush`=`idex_bubble`=0. `clr` mid-MWAIT aborts the wait.
- **Load-use latency:** exactly 1 stall cycle. The next cycle has the load in MEM, and forwarding covers it.
- **Memory freeze:** `mem_access` rising in cycle t gives `pipe_en`=0 for cycles t..t+MEMWAIT-1 and 1 at t+MEMWAIT (MDONE).
- **Simultaneous freeze and branch/RAW:** freeze wins. The branch/RAW condition is re-evaluated when the freeze ends, since the inputs are held.

## Configuration
- `HAZARD_FWD_EN` defined: the core has EX/MEM forwarding. RAW stall = load-use only.
- `HAZARD_FWD_EN` undefined: the core has no forwarding. RAW stall = any `ex_regwrite` match on `ex_rd`, OR any `mem_regwrite` match on `mem_rd`. A dependent instruction stalls up to 2 cycles. The register file writes in the first half-cycle, so WB needs no stall.

## Test plan
- Load r5 in EX, ID reads rs=5 → `pc_en`=0 and `idex_bubble`=1 for 1 cycle, then all enables 1; `stall_count`=1.
- Load r0 in EX, ID reads rs=0 → no stall, `pc_en`=1.
- `branch_taken`=1 together with load-use match → `ifid_flush`=1, `idex_bubble`=1, `pc_en`=1, no stall.
- MEMWAIT=2, `mem_access` held high from cycle 10 → `pipe_en`=0 in cycles 10–11 and 1 in 12; retriggers only after MDONE, when it is seen again in RUN.
- `clr`=1 during MWAIT → next cycle state RUN, `pipe_en`=1, `stall_count`=0.
- `HAZARD_FWD_EN` undefined, ALU write r3 in EX, ID reads rt=3 → 2 stall cycles (EX match, then MEM match); with the macro defined → 0 stall cycles.
